// File: rtl/usr_deser.sv
// ---------------------------------------------------------------------------
// usr_deser - serial-to-parallel deserializer with a one-word output holding
// register, selectable bit order and a sticky overrun flag.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset; clears all state
//   sin         serial data bit
//   sin_valid   sin carries a valid bit this cycle (no backpressure)
//   dir         bit order: 0 = LSB first, 1 = MSB first (latched per word)
//   flush       synchronous discard of a partially assembled word
//   pout        assembled parallel word, stable while pout_valid=1
//   pout_valid  pout holds an unconsumed word
//   pout_ready  consumer accepts pout when pout_valid=1
//   busy        partial word in progress (bit count 1..WIDTH-1)
//   overrun     sticky: a completed word was dropped
//   clr_ovr     synchronous clear of overrun (a same-edge overrun wins)
// ---------------------------------------------------------------------------
module usr_deser #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             dir,
    input  logic             flush,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] sreg_r;
    logic             dir_r;
    logic             busy_r;
    logic [WIDTH-1:0] pout_r;
    logic             pout_valid_r;
    logic             overrun_r;

    logic             accept_s;
    logic             dir_eff_s;
    logic [WIDTH-1:0] next_sreg_s;
    logic             complete_s;
    logic             drain_s;
    logic             load_s;
    logic             ovr_evt_s;

    // Next-value decode: bit acceptance, shift direction, completion and drain.
    always_comb begin
        accept_s    = 1'b0;
        dir_eff_s   = 1'b0;
        next_sreg_s = sreg_r;
        complete_s  = 1'b0;
        drain_s     = 1'b0;
        load_s      = 1'b0;
        ovr_evt_s   = 1'b0;

        accept_s = sin_valid & ~flush;

        // The first bit of a word uses the live dir; later bits use the latched copy.
        if (state_r == IDLE) begin
            dir_eff_s = dir;
        end else begin
            dir_eff_s = dir_r;
        end

        if (dir_eff_s) begin
            next_sreg_s = {sreg_r[WIDTH-2:0], sin};
        end else begin
            next_sreg_s = {sin, sreg_r[WIDTH-1:1]};
        end

        complete_s = accept_s & (count_r == LAST_C);
        drain_s    = pout_valid_r & pout_ready;
        // A completing word may enter the holding register in the same edge
        // that the previous word is drained, giving back-to-back throughput.
        load_s     = complete_s & (~pout_valid_r | pout_ready);
        ovr_evt_s  = complete_s & pout_valid_r & ~pout_ready;
    end

    // Word-assembly FSM: state, bit count, shift register, latched bit order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            count_r <= ZERO_C;
            sreg_r  <= {WIDTH{1'b0}};
            dir_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else if (flush) begin
            state_r <= IDLE;
            count_r <= ZERO_C;
            busy_r  <= 1'b0;
        end else if (accept_s) begin
            sreg_r <= next_sreg_s;
            case (state_r)
                IDLE: begin
                    dir_r   <= dir;
                    state_r <= SHIFT;
                    count_r <= ONE_C;
                    busy_r  <= 1'b1;
                end
                SHIFT: begin
                    if (complete_s) begin
                        state_r <= IDLE;
                        count_r <= ZERO_C;
                        busy_r  <= 1'b0;
                    end else begin
                        count_r <= count_r + ONE_C;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    count_r <= ZERO_C;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register and sticky overrun flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pout_r       <= {WIDTH{1'b0}};
            pout_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            if (load_s) begin
                pout_r       <= next_sreg_s;
                pout_valid_r <= 1'b1;
            end else if (drain_s) begin
                pout_valid_r <= 1'b0;
            end

            if (ovr_evt_s) begin
                overrun_r <= 1'b1;
            end else if (clr_ovr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign pout       = pout_r;
    assign pout_valid = pout_valid_r;
    assign busy       = busy_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_usr_deser.sv
// ---------------------------------------------------------------------------
// tb_usr_deser - self-checking bench for usr_deser (WIDTH=4): a vector table
// for the basic bit-order and gap cases, hand-written sequences for overrun,
// flush and reset, and a scoreboarded back-to-back word stream.
// ---------------------------------------------------------------------------
module tb_usr_deser;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         sin;
    logic         sin_valid;
    logic         dir;
    logic         flush;
    logic [W-1:0] pout;
    logic         pout_valid;
    logic         pout_ready;
    logic         busy;
    logic         overrun;
    logic         clr_ovr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] sb_q[$];
    bit           sb_en = 1'b0;

    typedef struct {
        logic         v, s, d, f, r, c;
        logic         ebusy, epv;
        logic [W-1:0] epout;
        logic         eovr;
    } vec_t;

    vec_t vecs[21];

    usr_deser #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .dir        (dir),
        .flush      (flush),
        .pout       (pout),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .busy       (busy),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp_v);
        end
    endtask

    // Apply one cycle of inputs; outputs are read 1 time unit after the edge.
    task automatic step(input logic v, s, d, f, r, c);
        logic [W-1:0] e;
        sin_valid  = v;
        sin        = s;
        dir        = d;
        flush      = f;
        pout_ready = r;
        clr_ovr    = c;
        if (sb_en && pout_valid && pout_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_word", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_word", pout, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Serialise a word in the requested bit order on consecutive cycles.
    task automatic send_word(input logic [W-1:0] w, input logic d,
                             input logic r_early, input logic r_last, input logic c_last);
        logic b;
        for (int i = 0; i < W; i++) begin
            b = d ? w[W-1-i] : w[i];
            if (i == W - 1) step(1'b1, b, d, 1'b0, r_last, c_last);
            else            step(1'b1, b, d, 1'b0, r_early, 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] w;
        logic         d;

        // v  s  d  f  r  c | busy pv pout  ovr
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hD, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hD, 1'b0};
        // MSB first, dir flipped to 0 after the first bit
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hD, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hD, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hD, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hB, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hB, 1'b0};
        // LSB first 0,1,0,1 with two gap cycles between bits
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 1'b0};

        reset = 1'b0; sin = 1'b0; sin_valid = 1'b0; dir = 1'b0;
        flush = 1'b0; pout_ready = 1'b0; clr_ovr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_pout", pout, 0);
        chk("rst_pout_valid", pout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].f, vecs[i].r, vecs[i].c);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].ebusy);
            chk($sformatf("vec%0d_pout_valid", i), pout_valid, vecs[i].epv);
            chk($sformatf("vec%0d_pout", i), pout, vecs[i].epout);
            chk($sformatf("vec%0d_overrun", i), overrun, vecs[i].eovr);
        end

        // Overrun: second word dropped while the first is unconsumed.
        send_word(4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_w1_valid", pout_valid, 1);
        chk("ovr_w1_pout", pout, 4'hA);
        send_word(4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_w2_pout_kept", pout, 4'hA);
        chk("ovr_w2_overrun", overrun, 1);
        chk("ovr_w2_valid", pout_valid, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_clear", overrun, 0);
        // clr_ovr on the same edge as an overrun: set wins.
        send_word(4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_set_wins", overrun, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_clear2", overrun, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_drain_valid", pout_valid, 0);
        chk("ovr_drain_pout_kept", pout, 4'hA);

        // Drain on the completing edge of word 2: replaced, no overrun.
        send_word(4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("swap_pout", pout, 4'h5);
        chk("swap_valid", pout_valid, 1);
        chk("swap_overrun", overrun, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("swap_drain_valid", pout_valid, 0);

        // Flush with a valid bit: partial word and that bit are discarded.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_pre_busy", busy, 1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("flush_busy", busy, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_3bits_busy", busy, 1);
        chk("flush_3bits_valid", pout_valid, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_word_pout", pout, 4'hF);
        chk("flush_word_valid", pout_valid, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-word with a valid word held.
        send_word(4'hD, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstmid_pre_pout", pout, 4'hD);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sin_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_pout", pout, 0);
        chk("rstmid_valid", pout_valid, 0);
        chk("rstmid_busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rstmid_new_busy", busy, 1);
        chk("rstmid_new_valid", pout_valid, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rstmid_new_pout", pout, 4'hC);
        chk("rstmid_new_valid2", pout_valid, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back words with random order, scoreboarded at the handshake.
        sb_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w = W'($urandom_range(0, 15));
            d = 1'($urandom_range(0, 1));
            sb_q.push_back(w);
            send_word(w, d, 1'b1, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        sb_en = 1'b0;
        chk("sb_words_left", sb_q.size(), 0);
        chk("sb_overrun", overrun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
